mrisc_control_fsm: RTL and testbench

//  Multi-cycle control unit for KGP miniRISC; producer side of the ALU control interface.

---
 rtl/mrisc_ctrl_pkg.sv | 139 +++++++++++++
 rtl/mrisc_branch_eval.sv | 28 ++
 rtl/mrisc_control_fsm.sv | 219 +++++++++++++++++++++
 tb/tb_mrisc_control_fsm.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrisc_ctrl_pkg.sv
// mrisc_ctrl_pkg: encodings shared by the miniRISC control unit.
// Opcodes, functs, ALU codes, FSM states, fault codes and the decoder.
package mrisc_ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_RS  = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000001;
    localparam logic [5:0] OP_COMPI = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b000101;
    localparam logic [5:0] OP_BR    = 6'b001000;
    localparam logic [5:0] OP_BLTZ  = 6'b001001;
    localparam logic [5:0] OP_BZ    = 6'b001010;
    localparam logic [5:0] OP_BNZ   = 6'b001011;
    localparam logic [5:0] OP_BCY   = 6'b001100;
    localparam logic [5:0] OP_BNCY  = 6'b001101;
    localparam logic [5:0] OP_JR    = 6'b001110;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [4:0] FN_ADD  = 5'b00001;
    localparam logic [4:0] FN_COMP = 5'b00010;
    localparam logic [4:0] FN_AND  = 5'b00011;
    localparam logic [4:0] FN_XOR  = 5'b00100;
    localparam logic [4:0] FN_DIFF = 5'b00101;
    localparam logic [4:0] FN_SLL  = 5'b01000;
    localparam logic [4:0] FN_SRL  = 5'b01001;
    localparam logic [4:0] FN_SRA  = 5'b01011;
    localparam logic [4:0] FN_SLLV = 5'b01100;
    localparam logic [4:0] FN_SRLV = 5'b01101;
    localparam logic [4:0] FN_SRAV = 5'b01111;

    // Shifts are 1csa: c=shamt source, s=right, a=arithmetic.
    localparam logic [3:0] ALU_PASSA = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_DIFF  = 4'b0100;
    localparam logic [3:0] ALU_COMP  = 4'b0101;
    localparam logic [3:0] ALU_SLLV  = 4'b1000;
    localparam logic [3:0] ALU_SRLV  = 4'b1010;
    localparam logic [3:0] ALU_SRAV  = 4'b1011;
    localparam logic [3:0] ALU_SLL   = 4'b1100;
    localparam logic [3:0] ALU_SRL   = 4'b1110;
    localparam logic [3:0] ALU_SRA   = 4'b1111;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JR,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    typedef struct packed {
        op_class_e  cls;
        logic [3:0] alu_code;
        logic       srcb_imm;
        logic       sets_carry;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op,
                                    input logic [4:0] funct);
        dec_t d;
        d.cls        = CLS_ILLEGAL;
        d.alu_code   = ALU_PASSA;
        d.srcb_imm   = 1'b0;
        d.sets_carry = 1'b0;
        case (op)
            OP_RTYPE: begin
                d.cls = CLS_ALU;
                case (funct)
                    FN_ADD: begin
                        d.alu_code   = ALU_ADD;
                        d.sets_carry = 1'b1;
                    end
                    FN_COMP: begin
                        d.alu_code   = ALU_COMP;
                        d.sets_carry = 1'b1;
                    end
                    FN_AND:  d.alu_code = ALU_AND;
                    FN_XOR:  d.alu_code = ALU_XOR;
                    FN_DIFF: d.alu_code = ALU_DIFF;
                    FN_SLL:  d.alu_code = ALU_SLL;
                    FN_SRL:  d.alu_code = ALU_SRL;
                    FN_SRA:  d.alu_code = ALU_SRA;
                    FN_SLLV: d.alu_code = ALU_SLLV;
                    FN_SRLV: d.alu_code = ALU_SRLV;
                    FN_SRAV: d.alu_code = ALU_SRAV;
                    default: d.cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                d.cls        = CLS_ALU;
                d.alu_code   = ALU_ADD;
                d.srcb_imm   = 1'b1;
                d.sets_carry = 1'b1;
            end
            OP_COMPI: begin
                d.cls        = CLS_ALU;
                d.alu_code   = ALU_COMP;
                d.srcb_imm   = 1'b1;
                d.sets_carry = 1'b1;
            end
            OP_LW: begin
                d.cls      = CLS_LOAD;
                d.alu_code = ALU_ADD;
                d.srcb_imm = 1'b1;
            end
            OP_SW: begin
                d.cls      = CLS_STORE;
                d.alu_code = ALU_ADD;
                d.srcb_imm = 1'b1;
            end
            OP_BR, OP_BLTZ, OP_BZ,
            OP_BNZ, OP_BCY, OP_BNCY: d.cls = CLS_BRANCH;
            OP_JR:   d.cls = CLS_JR;
            OP_HALT: d.cls = CLS_HALT;
            default: d.cls = CLS_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mrisc_branch_eval.sv
// mrisc_branch_eval: branch/jump resolution from opcode and ALU flags.
// Purely combinational; carry_i is the carry saved by the last add/comp.
module mrisc_branch_eval
    import mrisc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic       fzero_i,
    input  logic       fsign_i,
    input  logic       carry_i,
    output logic       taken_o
);

    // Branch condition select per opcode.
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            OP_BR:   taken_o = 1'b1;
            OP_BLTZ: taken_o = fsign_i;
            OP_BZ:   taken_o = fzero_i;
            OP_BNZ:  taken_o = !fzero_i;
            OP_BCY:  taken_o = carry_i;
            OP_BNCY: taken_o = !carry_i;
            OP_JR:   taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mrisc_control_fsm.sv
// mrisc_control_fsm: multi-cycle control unit for KGP miniRISC.
// Optional MRISC_CTRL_PERF_EN adds cyc_cnt/ret_cnt perf counters.
module mrisc_control_fsm
    import mrisc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        fzero,
    input  logic        fsign,
    input  logic        fcarry,
    input  logic        fequal,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [3:0]  alu_code,
    output logic [4:0]  alu_shamt,
    output logic        alu_srcb_imm,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        halted,
    output logic [1:0]  fault
`ifdef MRISC_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] cyc_cnt,
    output logic [PERF_W-1:0] ret_cnt
`endif
);

    localparam int TO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]      state_q, state_d;
    logic [5:0]      op_q, op_d;
    logic [4:0]      shamt_q, shamt_d;
    logic [4:0]      funct_q, funct_d;
    logic            carry_q, carry_d;
    logic [1:0]      fault_q, fault_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    dec_t dec;
    logic taken;
    logic req_wait;
    logic to_hit;

    // Operand fields and the flag equality bit are consumed by the datapath.
    logic unused_ok;
    assign unused_ok = ^{fequal, instr[25:16], instr[10:5], PERF_W[0]};

    assign dec = decode(op_q, funct_q);

    mrisc_branch_eval u_branch_eval (
        .op_i    (op_q),
        .fzero_i (fzero),
        .fsign_i (fsign),
        .carry_i (carry_q),
        .taken_o (taken)
    );

    assign req_wait = (state_q == ST_FETCH && !imem_ack) ||
                      (state_q == ST_MEM && !dmem_ack);
    assign to_hit   = (MEM_TIMEOUT != 0) && req_wait &&
                      (to_cnt_q == TO_LAST);

    // Next-state, IR capture, carry and fault/timeout bookkeeping.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        shamt_d  = shamt_q;
        funct_d  = funct_q;
        carry_d  = carry_q;
        fault_d  = fault_q;
        to_cnt_d = '0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    op_d    = instr[31:26];
                    shamt_d = instr[15:11];
                    funct_d = instr[4:0];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec.cls == CLS_ILLEGAL) begin
                    state_d = ST_HALT;
                    fault_d = FAULT_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec.sets_carry) carry_d = fcarry;
                case (dec.cls)
                    CLS_ALU:   state_d = ST_WB;
                    CLS_LOAD:  state_d = ST_MEM;
                    CLS_STORE: state_d = ST_MEM;
                    CLS_HALT:  state_d = ST_HALT;
                    default:   state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = (dec.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
        if (req_wait) to_cnt_d = to_cnt_q + 1'b1;
        if (to_hit) begin
            state_d  = ST_HALT;
            fault_d  = FAULT_TIMEOUT;
            to_cnt_d = '0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            op_q     <= '0;
            shamt_q  <= '0;
            funct_q  <= '0;
            carry_q  <= 1'b0;
            fault_q  <= FAULT_NONE;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            shamt_q  <= shamt_d;
            funct_q  <= funct_d;
            carry_q  <= carry_d;
            fault_q  <= fault_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Datapath controls from state and IR. The only input-qualified
    // strobes are the fetch-accept enables, which must coincide with the
    // cycle in which instr is valid, and taken branches, which resolve
    // on the same-cycle ALU flags.
    always_comb begin
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_SEQ;
        alu_code     = ALU_PASSA;
        alu_shamt    = '0;
        alu_srcb_imm = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ack;
                    pc_write = imem_ack;
                end
                ST_EXEC: begin
                    alu_code     = dec.alu_code;
                    alu_shamt    = shamt_q;
                    alu_srcb_imm = dec.srcb_imm;
                    if ((dec.cls == CLS_BRANCH || dec.cls == CLS_JR)
                        && taken) begin
                        pc_write = 1'b1;
                        pc_src   = (dec.cls == CLS_JR) ? PC_SRC_RS
                                                       : PC_SRC_BR;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (dec.cls == CLS_STORE);
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = (dec.cls == CLS_LOAD);
                end
                default: ;
            endcase
        end
    end

    assign halted = (state_q == ST_HALT);
    assign fault  = fault_q;

`ifdef MRISC_CTRL_PERF_EN
    logic [PERF_W-1:0] cyc_cnt_q;
    logic [PERF_W-1:0] ret_cnt_q;

    // Free-running cycle and retirement counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            if (state_q != ST_HALT) cyc_cnt_q <= cyc_cnt_q + 1'b1;
            if (state_d == ST_FETCH && state_q != ST_FETCH) begin
                ret_cnt_q <= ret_cnt_q + 1'b1;
            end
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_mrisc_control_fsm.sv
// tb_mrisc_control_fsm: cycle-by-cycle directed vectors for the control FSM.
// A second instance with a short memory timeout covers the fault path.
module tb_mrisc_control_fsm;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [3:0] alu_code;
        logic [4:0] alu_shamt;
        logic       srcb_imm;
        logic       reg_write;
        logic       wb_sel;
        logic       halted;
        logic [1:0] fault;
    } out_t;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] instr;
        logic        ia;
        logic        da;
        logic        fz;
        logic        fs;
        logic        fc;
        out_t        exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ack, dmem_ack;
    logic        fzero, fsign, fcarry, fequal;

    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic [3:0]  alu_code;
    logic [4:0]  alu_shamt;
    logic        alu_srcb_imm, reg_write, wb_sel, halted;
    logic [1:0]  fault;

    logic        t_imem_req, t_dmem_req, t_dmem_we, t_ir_write, t_pc_write;
    logic [1:0]  t_pc_src;
    logic [3:0]  t_alu_code;
    logic [4:0]  t_alu_shamt;
    logic        t_alu_srcb_imm, t_reg_write, t_wb_sel, t_halted;
    logic [1:0]  t_fault;

`ifdef MRISC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt, t_cyc_cnt, t_ret_cnt;
`endif

    out_t act_dut, act_to;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tv[$];

    mrisc_control_fsm u_dut (
        .clk(clk), .rst(rst), .instr(instr),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .fzero(fzero), .fsign(fsign), .fcarry(fcarry), .fequal(fequal),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_code(alu_code), .alu_shamt(alu_shamt),
        .alu_srcb_imm(alu_srcb_imm), .reg_write(reg_write),
        .wb_sel(wb_sel), .halted(halted), .fault(fault)
`ifdef MRISC_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    mrisc_control_fsm #(.MEM_TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst), .instr(instr),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .fzero(fzero), .fsign(fsign), .fcarry(fcarry), .fequal(fequal),
        .imem_req(t_imem_req), .dmem_req(t_dmem_req), .dmem_we(t_dmem_we),
        .ir_write(t_ir_write), .pc_write(t_pc_write), .pc_src(t_pc_src),
        .alu_code(t_alu_code), .alu_shamt(t_alu_shamt),
        .alu_srcb_imm(t_alu_srcb_imm), .reg_write(t_reg_write),
        .wb_sel(t_wb_sel), .halted(t_halted), .fault(t_fault)
`ifdef MRISC_CTRL_PERF_EN
        , .cyc_cnt(t_cyc_cnt), .ret_cnt(t_ret_cnt)
`endif
    );

    assign act_dut = {imem_req, dmem_req, dmem_we, ir_write, pc_write,
                      pc_src, alu_code, alu_shamt, alu_srcb_imm,
                      reg_write, wb_sel, halted, fault};
    assign act_to  = {t_imem_req, t_dmem_req, t_dmem_we, t_ir_write,
                      t_pc_write, t_pc_src, t_alu_code, t_alu_shamt,
                      t_alu_srcb_imm, t_reg_write, t_wb_sel, t_halted,
                      t_fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_r(input logic [4:0] rs,
                                         input logic [4:0] rt,
                                         input logic [4:0] sh,
                                         input logic [4:0] fn);
        return {6'b000000, rs, rt, sh, 6'b000000, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op,
                                         input logic [4:0] rs,
                                         input logic [4:0] rt,
                                         input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic out_t e_idle();
        out_t o = '0;
        return o;
    endfunction

    function automatic out_t e_fetch(input logic ack);
        out_t o = '0;
        o.imem_req = 1'b1;
        o.ir_write = ack;
        o.pc_write = ack;
        return o;
    endfunction

    function automatic out_t e_exe(input logic [3:0] code,
                                   input logic [4:0] sh,
                                   input logic imm,
                                   input logic pcw,
                                   input logic [1:0] src);
        out_t o = '0;
        o.alu_code  = code;
        o.alu_shamt = sh;
        o.srcb_imm  = imm;
        o.pc_write  = pcw;
        o.pc_src    = src;
        return o;
    endfunction

    function automatic out_t e_mem(input logic we);
        out_t o = '0;
        o.dmem_req = 1'b1;
        o.dmem_we  = we;
        return o;
    endfunction

    function automatic out_t e_wb(input logic sel);
        out_t o = '0;
        o.reg_write = 1'b1;
        o.wb_sel    = sel;
        return o;
    endfunction

    function automatic out_t e_halt(input logic [1:0] f);
        out_t o = '0;
        o.halted = 1'b1;
        o.fault  = f;
        return o;
    endfunction

    task automatic add(input string nm, input logic r,
                       input logic [31:0] ins, input logic ia,
                       input logic da, input logic fz, input logic fs,
                       input logic fc, input out_t e);
        vec_t v;
        v.name = nm; v.rst = r; v.instr = ins; v.ia = ia; v.da = da;
        v.fz = fz; v.fs = fs; v.fc = fc; v.exp = e;
        tv.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [31:0] ins,
                         input logic ia, input logic da, input logic fz,
                         input logic fs, input logic fc);
        @(posedge clk);
        #1;
        rst = r; instr = ins; imem_ack = ia; dmem_ack = da;
        fzero = fz; fsign = fs; fcarry = fc;
        @(negedge clk);
    endtask

    task automatic check(input string nm, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    logic [31:0] ADD, ADDC, SRA3, SRLV, BCY, BZ, BNZ, JR, ADDI, LW, SW;
    logic [31:0] HALT, ILL;

    initial begin
        ADD  = mk_r(5'd2, 5'd3, 5'd0, 5'b00001);
        ADDC = mk_r(5'd4, 5'd5, 5'd0, 5'b00001);
        SRA3 = mk_r(5'd2, 5'd3, 5'd3, 5'b01011);
        SRLV = mk_r(5'd2, 5'd3, 5'd0, 5'b01101);
        BCY  = mk_i(6'b001100, 5'd1, 5'd0, 16'h0010);
        BZ   = mk_i(6'b001010, 5'd1, 5'd0, 16'h0020);
        BNZ  = mk_i(6'b001011, 5'd1, 5'd0, 16'h0020);
        JR   = mk_i(6'b001110, 5'd7, 5'd0, 16'h0000);
        ADDI = mk_i(6'b000001, 5'd2, 5'd1, 16'h0007);
        LW   = mk_i(6'b000100, 5'd2, 5'd1, 16'h0004);
        SW   = mk_i(6'b000101, 5'd2, 5'd1, 16'h0004);
        HALT = mk_i(6'b111111, 5'd0, 5'd0, 16'h0000);
        ILL  = mk_i(6'b010101, 5'd0, 5'd0, 16'h0000);

        rst = 1'b1; instr = '0; imem_ack = 0; dmem_ack = 0;
        fzero = 0; fsign = 0; fcarry = 0; fequal = 0;
        repeat (2) drive(1, 0, 0, 0, 0, 0, 0);

        add("rst",       1, 0,    0, 0, 0, 0, 0, e_idle());
        add("t1 wait0",  0, 0,    0, 0, 0, 0, 0, e_fetch(0));
        add("t1 wait1",  0, 0,    0, 0, 0, 0, 0, e_fetch(0));
        add("t1 ack",    0, ADD,  1, 0, 0, 0, 0, e_fetch(1));
        add("t1 dec",    0, 0,    0, 0, 0, 0, 0, e_idle());
        add("t1 exe",    0, 0,    0, 0, 0, 0, 0,
            e_exe(4'b0001, 5'd0, 0, 0, 2'd0));
        add("t1 wb",     0, 0,    0, 0, 0, 0, 0, e_wb(0));
        add("t2 sra ack", 0, SRA3, 1, 0, 0, 0, 0, e_fetch(1));
        add("t2 sra dec", 0, 0,   0, 0, 0, 0, 0, e_idle());
        add("t2 sra exe", 0, 0,   0, 0, 0, 0, 0,
            e_exe(4'b1111, 5'd3, 0, 0, 2'd0));
        add("t2 sra wb", 0, 0,    0, 0, 0, 0, 0, e_wb(0));
        add("t2 srlv ack", 0, SRLV, 1, 0, 0, 0, 0, e_fetch(1));
        add("t2 srlv dec", 0, 0,  0, 0, 0, 0, 0, e_idle());
        add("t2 srlv exe", 0, 0,  0, 0, 0, 0, 0,
            e_exe(4'b1010, 5'd0, 0, 0, 2'd0));
        add("t2 srlv wb", 0, 0,   0, 0, 0, 0, 0, e_wb(0));
        add("t3 add ack", 0, ADDC, 1, 0, 0, 0, 0, e_fetch(1));
        add("t3 add dec", 0, 0,   0, 0, 0, 0, 0, e_idle());
        add("t3 add exe c1", 0, 0, 0, 0, 0, 0, 1,
            e_exe(4'b0001, 5'd0, 0, 0, 2'd0));
        add("t3 add wb", 0, 0,    0, 0, 0, 0, 0, e_wb(0));
        add("t3 bcy ack", 0, BCY, 1, 0, 0, 0, 0, e_fetch(1));
        add("t3 bcy dec", 0, 0,   0, 0, 0, 0, 0, e_idle());
        add("t3 bcy taken", 0, 0, 0, 0, 0, 0, 0,
            e_exe(4'b0000, 5'd0, 0, 1, 2'd1));
        add("t3 add2 ack", 0, ADDC, 1, 0, 0, 0, 0, e_fetch(1));
        add("t3 add2 dec", 0, 0,  0, 0, 0, 0, 0, e_idle());
        add("t3 add2 exe c0", 0, 0, 0, 0, 0, 0, 0,
            e_exe(4'b0001, 5'd0, 0, 0, 2'd0));
        add("t3 add2 wb", 0, 0,   0, 0, 0, 0, 0, e_wb(0));
        add("t3 bcy2 ack", 0, BCY, 1, 0, 0, 0, 1, e_fetch(1));
        add("t3 bcy2 dec", 0, 0,  0, 0, 0, 0, 1, e_idle());
        add("t3 bcy not taken", 0, 0, 0, 0, 0, 0, 1,
            e_exe(4'b0000, 5'd0, 0, 0, 2'd0));
        add("bz ack",    0, BZ,   1, 0, 0, 0, 0, e_fetch(1));
        add("bz dec",    0, 0,    0, 0, 0, 0, 0, e_idle());
        add("bz taken",  0, 0,    0, 0, 1, 0, 0,
            e_exe(4'b0000, 5'd0, 0, 1, 2'd1));
        add("bnz ack",   0, BNZ,  1, 0, 0, 0, 0, e_fetch(1));
        add("bnz dec",   0, 0,    0, 0, 0, 0, 0, e_idle());
        add("bnz not taken", 0, 0, 0, 0, 1, 0, 0,
            e_exe(4'b0000, 5'd0, 0, 0, 2'd0));
        add("jr ack",    0, JR,   1, 0, 0, 0, 0, e_fetch(1));
        add("jr dec",    0, 0,    0, 0, 0, 0, 0, e_idle());
        add("jr exe",    0, 0,    0, 0, 0, 0, 0,
            e_exe(4'b0000, 5'd0, 0, 1, 2'd2));
        add("addi ack",  0, ADDI, 1, 0, 0, 0, 0, e_fetch(1));
        add("addi dec",  0, 0,    0, 0, 0, 0, 0, e_idle());
        add("addi exe",  0, 0,    0, 0, 0, 0, 0,
            e_exe(4'b0001, 5'd0, 1, 0, 2'd0));
        add("addi wb",   0, 0,    0, 0, 0, 0, 0, e_wb(0));
        add("t4 lw ack", 0, LW,   1, 0, 0, 0, 0, e_fetch(1));
        add("t4 lw dec", 0, 0,    0, 0, 0, 0, 0, e_idle());
        add("t4 lw exe", 0, 0,    0, 0, 0, 0, 0,
            e_exe(4'b0001, 5'd0, 1, 0, 2'd0));
        for (int i = 0; i < 5; i++) begin
            add($sformatf("t4 lw mem wait%0d", i), 0, 0, 0, 0, 0, 0, 0,
                e_mem(0));
        end
        add("t4 lw mem ack", 0, 0, 0, 1, 0, 0, 0, e_mem(0));
        add("t4 lw wb",  0, 0,    0, 0, 0, 0, 0, e_wb(1));
        add("sw ack",    0, SW,   1, 0, 0, 0, 0, e_fetch(1));
        add("sw dec",    0, 0,    0, 0, 0, 0, 0, e_idle());
        add("sw exe",    0, 0,    0, 0, 0, 0, 0,
            e_exe(4'b0001, 5'd0, 1, 0, 2'd0));
        add("sw mem ack", 0, 0,   0, 1, 0, 0, 0, e_mem(1));
        add("sw to fetch", 0, 0,  0, 0, 0, 0, 0, e_fetch(0));
        add("halt ack",  0, HALT, 1, 0, 0, 0, 0, e_fetch(1));
        add("halt dec",  0, 0,    0, 0, 0, 0, 0, e_idle());
        add("halt exe",  0, 0,    0, 0, 0, 0, 0, e_idle());
        add("halted",    0, 0,    0, 0, 0, 0, 0, e_halt(2'd0));
        add("halt absorbs", 0, ADD, 1, 1, 0, 0, 0, e_halt(2'd0));

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].instr, tv[i].ia, tv[i].da,
                  tv[i].fz, tv[i].fs, tv[i].fc);
            check(tv[i].name, act_dut, tv[i].exp);
        end

        // Memory timeout on the short-timeout instance.
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, LW, 1, 0, 0, 0, 0);
        check("t5 lw ack", act_to, e_fetch(1));
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t5 lw dec", act_to, e_idle());
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t5 lw exe", act_to, e_exe(4'b0001, 5'd0, 1, 0, 2'd0));
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            check($sformatf("t5 mem wait%0d", i), act_to, e_mem(0));
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t5 timeout halt", act_to, e_halt(2'd2));
        drive(0, 0, 1, 1, 0, 0, 0);
        check("t5 fault sticky", act_to, e_halt(2'd2));
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t5 rst clears", act_to, e_fetch(0));

        // Illegal opcode, then reset in the middle of a load.
        drive(0, ILL, 1, 0, 0, 0, 0);
        check("t6 ill ack", act_dut, e_fetch(1));
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t6 ill dec", act_dut, e_idle());
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t6 ill halt", act_dut, e_halt(2'd1));
        drive(0, 0, 1, 0, 0, 0, 0);
        check("t6 ill sticky", act_dut, e_halt(2'd1));
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, LW, 1, 0, 0, 0, 0);
        check("t6 lw ack", act_dut, e_fetch(1));
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t6 in mem", act_dut, e_mem(0));
        drive(1, 0, 0, 0, 0, 0, 0);
        check("t6 rst in mem", act_dut, e_idle());
        drive(0, 0, 0, 0, 0, 0, 0);
        check("t6 after rst", act_dut, e_fetch(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
